// File: rtl/cmd_queue_pkg.sv
// -----------------------------------------------------------------------------
// cmd_queue_pkg
// Shared types and defaults for the command queue in front of the issuer.
//   PROC_COUNT  number of processors a command can target
//   CMDQ_DEPTH  default queue depth for the top-level instance
//   cmd_t       one queued command (processor id, opcode, argument)
// -----------------------------------------------------------------------------
package cmd_queue_pkg;

  localparam int PROC_COUNT = 4;
  localparam int CMDQ_DEPTH = 16;
  localparam int PROC_W     = $clog2(PROC_COUNT);

  typedef struct packed {
    logic [PROC_W-1:0] proc_id;
    logic [3:0]        opcode;
    logic [9:0]        arg;
  } cmd_t;

endpackage

// File: rtl/cmd_queue_if.sv
// -----------------------------------------------------------------------------
// cmd_queue_if
// Bus between the host/issuer side and the command queue.
//   master : host + issuer (drives i_*, observes o_*)
//   slave  : cmd_queue     (observes i_*, drives o_*)
//
// Handshake semantics:
//   push      : a command is taken on a rising clock edge when i_push && !o_full;
//               otherwise it is dropped and the host must hold/retry it.
//   pop       : the head (o_cmd) is handed to the issuer on an edge where
//               i_pop && o_valid; i_pop without o_valid has no effect.
//   writeback : the in-flight command returns on an edge with i_wb && o_inflight.
//   retire    : the in-flight command completes on an edge with
//               i_retire && o_inflight && !i_wb (writeback has priority).
// -----------------------------------------------------------------------------
interface cmd_queue_if #(
  parameter int DEPTH = cmd_queue_pkg::CMDQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  import cmd_queue_pkg::*;

  logic             i_push;
  cmd_t             i_push_cmd;
  logic             o_full;
  logic             o_valid;
  cmd_t             o_cmd;
  logic             i_pop;
  logic             i_wb;
  cmd_t             i_wb_cmd;
  logic             i_retire;
  logic             o_inflight;
  logic [CNT_W-1:0] o_count;
  logic             o_all_blocked;

  modport master (
    output i_push, i_push_cmd, i_pop, i_wb, i_wb_cmd, i_retire,
    input  o_full, o_valid, o_cmd, o_inflight, o_count, o_all_blocked
  );

  modport slave (
    input  i_push, i_push_cmd, i_pop, i_wb, i_wb_cmd, i_retire,
    output o_full, o_valid, o_cmd, o_inflight, o_count, o_all_blocked
  );

endinterface

// File: rtl/cmd_queue_mem.sv
// -----------------------------------------------------------------------------
// cmdq_mem
// DEPTH x cmd_t register file, two write ports and one asynchronous read port.
//   clk_i                      clock
//   wb_we_i / wb_addr_i / wb_data_i        writeback write port
//   push_we_i / push_addr_i / push_data_i  host push write port
//   rd_addr_i / rd_data_o                  combinational read port
// The two write addresses never collide: the push slot is always placed one
// past the writeback slot when both are active. Storage has no reset.
// -----------------------------------------------------------------------------
module cmdq_mem #(
  parameter int DEPTH = cmd_queue_pkg::CMDQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 wb_we_i,
  input  logic [PTR_W-1:0]     wb_addr_i,
  input  cmd_queue_pkg::cmd_t  wb_data_i,
  input  logic                 push_we_i,
  input  logic [PTR_W-1:0]     push_addr_i,
  input  cmd_queue_pkg::cmd_t  push_data_i,
  input  logic [PTR_W-1:0]     rd_addr_i,
  output cmd_queue_pkg::cmd_t  rd_data_o
);
  import cmd_queue_pkg::*;

  cmd_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wb_we_i) begin
      mem_q[wb_addr_i] <= wb_data_i;
    end
    if (push_we_i) begin
      mem_q[push_addr_i] <= push_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cmd_queue.sv
// -----------------------------------------------------------------------------
// cmd_queue
// First-word-fall-through command FIFO feeding the issuer. Commands popped by
// the issuer stay "in flight" until they are either written back (re-queued at
// the tail) or retired. One slot is always kept free for the in-flight command
// so a writeback can never overflow. o_all_blocked flags that every stored
// command has been written back without any intervening progress.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : push / pop / writeback / retire handshake and status
// -----------------------------------------------------------------------------
module cmd_queue #(
  parameter int DEPTH = cmd_queue_pkg::CMDQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  cmd_queue_if.slave bus
);
  import cmd_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wb_run_q, wb_run_d;
  logic             inflight_q, inflight_d;
  logic             full_q, full_d;
  logic             blocked_q, blocked_d;

  logic             valid;
  logic             pop_en, wb_en, retire_en, push_en;
  logic [PTR_W-1:0] push_addr;
  logic [CNT_W:0]   occupancy_d;
  cmd_t             rd_data;

  // Only one command may be with the issuer at a time.
  assign valid     = (count_q != '0) && !inflight_q;
  assign pop_en    = bus.i_pop && valid;
  assign wb_en     = bus.i_wb && inflight_q;
  assign retire_en = bus.i_retire && inflight_q && !bus.i_wb;
  assign push_en   = bus.i_push && !full_q;

  // Writeback takes the tail slot first; a simultaneous push lands behind it.
  assign push_addr = wr_ptr_q + PTR_W'(wb_en);

  cmdq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i       (i_clk),
    .wb_we_i     (wb_en),
    .wb_addr_i   (wr_ptr_q),
    .wb_data_i   (bus.i_wb_cmd),
    .push_we_i   (push_en),
    .push_addr_i (push_addr),
    .push_data_i (bus.i_push_cmd),
    .rd_addr_i   (rd_ptr_q),
    .rd_data_o   (rd_data)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(wb_en) + PTR_W'(push_en);
    count_d  = count_q + CNT_W'(wb_en) + CNT_W'(push_en) - CNT_W'(pop_en);

    inflight_d = inflight_q;
    if (pop_en) begin
      inflight_d = 1'b1;
    end else if (wb_en || retire_en) begin
      inflight_d = 1'b0;
    end

    // Run of writebacks with no progress; saturates so it cannot wrap back
    // below the occupancy and hide a stall.
    wb_run_d = wb_run_q;
    if (retire_en || push_en) begin
      wb_run_d = '0;
    end else if (wb_en && (wb_run_q != '1)) begin
      wb_run_d = wb_run_q + CNT_W'(1);
    end

    // The in-flight command counts against capacity so its writeback fits.
    occupancy_d = {1'b0, count_d} + (CNT_W + 1)'(inflight_d);
    full_d      = occupancy_d >= (CNT_W + 1)'(DEPTH);
    blocked_d   = (wb_run_d >= count_d) && (count_d != '0) && !inflight_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wb_run_q   <= '0;
      inflight_q <= 1'b0;
      full_q     <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wb_run_q   <= wb_run_d;
      inflight_q <= inflight_d;
      full_q     <= full_d;
      blocked_q  <= blocked_d;
    end
  end

  assign bus.o_full        = full_q;
  assign bus.o_valid       = valid;
  // Forced to zero when no head is presented, so reset shows a clean bus
  // even though the storage itself is not cleared.
  assign bus.o_cmd         = valid ? rd_data : '0;
  assign bus.o_inflight    = inflight_q;
  assign bus.o_count       = count_q;
  assign bus.o_all_blocked = blocked_q;

  a_count_bound: assert property (
    @(posedge i_clk) disable iff (i_rst) count_q <= CNT_W'(DEPTH)
  );

  a_wb_has_slot: assert property (
    @(posedge i_clk) disable iff (i_rst) wb_en |-> (count_q < CNT_W'(DEPTH))
  );

endmodule
